rf_writeback_ctrl: RTL
======================

Name: rf_writeback_ctrl

Overview:
Write-side initiator for the 16x16-bit register file. It accepts writeback requests from the ALU and the load/memory unit, holds them in an in-order 4-entry queue, and drives the register file write port (Rd, Write_Data, wr) one write per granted cycle. It also gives the decode stage forwarding data for the two read addresses (Rs, Rt) while writes are still queued, so reads never return stale values.

Parameters:
DEPTH, 4, queue entries; power of two, minimum 2
AW, 4, register address width (16 registers)
DW, 16, data width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
alu_valid  input  1  ALU writeback request
alu_rd  input  4  ALU destination register
alu_data  input  16  ALU result
alu_ready  output  1  ALU request accepted this cycle when alu_valid=1
mem_valid  input  1  load writeback request
mem_rd  input  4  load destination register
mem_data  input  16  load data
mem_ready  output  1  load request accepted this cycle when mem_valid=1
rf_grant  input  1  register file write port available this cycle
Rd  output  4  register file write address
Write_Data  output  16  register file write data
wr  output  1  register file write enable
Rs  input  4  decode read address A
Rt  input  4  decode read address B
fwd_a_hit  output  1  a queued write targets Rs
fwd_a_data  output  16  data of the youngest queued write to Rs
fwd_b_hit  output  1  a queued write targets Rt
fwd_b_data  output  16  data of the youngest queued write to Rt
count  output  3  number of occupied queue entries (0..DEPTH)
full  output  1  count==DEPTH
empty  output  1  count==0

Behaviour:
- Reset (synchronous, active-high): on the next rising edge, count=0, read and write pointers=0, and every entry's valid bit is cleared. While empty: wr=0, Rd=0, Write_Data=0, fwd_*_hit=0, fwd_*_data=0, full=0, empty=1. Reset during operation drops every queued write; no wr pulse is produced in the reset cycle or the cycle after it.
- Arbitration (combinational):
  - alu_ready = ~full.
  - mem_ready = ~full & ~alu_valid. ALU has fixed priority.
  - At most one enqueue per cycle.
  - A full queue never accepts a request, even if a pop happens in the same cycle.
- Enqueue: on a rising edge where (alu_valid&alu_ready) or (mem_valid&mem_ready), write {rd, data} at the write pointer and increment the pointer modulo DEPTH.
- Drain:
  - wr = ~empty & rf_grant (combinational).
  - Rd and Write_Data are driven from the head entry whenever the queue is non-empty, and are 0 when it is empty.
  - Pop (advance the read pointer modulo DEPTH) on every rising edge where wr=1.
- Latency: a request accepted at edge N appears at the head no earlier than the cycle after N. With an empty queue and rf_grant=1, wr is high during cycle N+1 and the register updates at edge N+2. There is no combinational bypass from request to wr.
- Ordering: writes are strictly FIFO, including repeated writes to the same register. The last accepted write wins.
- Count:
  - Enqueue and pop on the same edge leave count unchanged.
  - Enqueue alone: count+1. Pop alone: count-1.
  - Neither overflow nor underflow is reachable, by construction.
- Forwarding:
  - fwd_a_hit=1 if any occupied entry has rd==Rs. fwd_a_data is the data of the youngest such entry (closest to the write pointer).
  - Port B uses Rt in the same way.
  - Purely combinational, with the same-cycle head included (a write in flight this cycle still forwards).
  - Unoccupied entries never match.
- R0 is not special: writes to address 0 are queued and forwarded like any other address.

Test Plan:
- Reset then single write: alu_valid=1, alu_rd=3, alu_data=16'hABCD for 1 cycle, rf_grant=1 -> wr=1, Rd=3, Write_Data=16'hABCD exactly one cycle later, for one cycle; count returns to 0.
- Priority: alu_valid=1 (rd=5, 16'h0001) and mem_valid=1 (rd=6, 16'h0002) in the same cycle -> mem_ready=0 and the ALU write is accepted; mem is accepted next cycle; wr order is R5 then R6.
- Full/backpressure: rf_grant=0, 5 ALU requests to R1..R5 -> the first 4 are accepted, full=1, alu_ready=0 on the 5th, wr stays 0; raise rf_grant -> 4 consecutive wr pulses R1..R4, then R5 is accepted only after full drops.
- Forwarding youngest: rf_grant=0, queue R7=16'h1111 then R7=16'h2222, Rs=7, Rt=8 -> fwd_a_hit=1, fwd_a_data=16'h2222, fwd_b_hit=0; drain -> hit clears after the second write pops.
- Simultaneous enqueue and pop: count=2, rf_grant=1, an ALU request each cycle -> count holds at 2 and the wr sequence matches the request order.
- Reset mid-operation: 3 entries queued with rf_grant=0, assert rst for 1 cycle with rf_grant=1 -> no wr pulse, count=0, empty=1, fwd hits 0.

Source files
------------

// File: rtl/rf_writeback_ctrl.sv
// Register-file writeback controller: in-order write queue fed by ALU and load
// writebacks, draining one write per granted cycle, with read-side forwarding.
module rf_writeback_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  input  logic [AW-1:0]                alu_rd,
  input  logic [DW-1:0]                alu_data,
  output logic                         alu_ready,
  input  logic                         mem_valid,
  input  logic [AW-1:0]                mem_rd,
  input  logic [DW-1:0]                mem_data,
  output logic                         mem_ready,
  input  logic                         rf_grant,
  output logic [AW-1:0]                Rd,
  output logic [DW-1:0]                Write_Data,
  output logic                         wr,
  input  logic [AW-1:0]                Rs,
  input  logic [AW-1:0]                Rt,
  output logic                         fwd_a_hit,
  output logic [DW-1:0]                fwd_a_data,
  output logic                         fwd_b_hit,
  output logic [DW-1:0]                fwd_b_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0]    rd_q   [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    wp, rp, idx;
  logic [CW-1:0]    cnt;
  logic             alu_take, push, pop;

  assign count     = cnt;
  assign full      = (cnt == CW'(DEPTH));
  assign empty     = (cnt == '0);
  assign alu_ready = ~full;
  assign mem_ready = ~full & ~alu_valid;
  assign alu_take  = alu_valid & alu_ready;
  assign push      = alu_take | (mem_valid & mem_ready);

  // Reset discards the queue, so a write presented in the reset cycle must not
  // reach the register file either.
  assign wr  = ~empty & rf_grant & ~rst;
  assign pop = wr;

  assign Rd         = empty ? '0 : rd_q[rp];
  assign Write_Data = empty ? '0 : data_q[rp];

  // Walk from oldest to youngest so the last match left standing is the youngest.
  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    fwd_a_hit  = 1'b0;
    fwd_a_data = '0;
    fwd_b_hit  = 1'b0;
    fwd_b_data = '0;
    idx        = rp;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rp + PW'(i);
      if (valid_q[idx] && rd_q[idx] == Rs) begin
        fwd_a_hit  = 1'b1;
        fwd_a_data = data_q[idx];
      end
      if (valid_q[idx] && rd_q[idx] == Rt) begin
        fwd_b_hit  = 1'b1;
        fwd_b_data = data_q[idx];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      valid_q <= '0;
    end else begin
      // A push and a pop never hit the same slot: that needs empty or full.
      if (push) begin
        valid_q[wp] <= 1'b1;
        wp          <= wp + 1'b1;
      end
      if (pop) begin
        valid_q[rp] <= 1'b0;
        rp          <= rp + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: payload storage is not reset; valid_q alone decides what is occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wp]   <= alu_take ? alu_rd   : mem_rd;
      data_q[wp] <= alu_take ? alu_data : mem_data;
    end
  end

endmodule
